// File: rtl/axis_mm2s_checker_if.sv
// rtl/axis_mm2s_checker_if.sv - AXI-Stream-like bundle carrying the MM2S read-back stream
// Purpose: groups tdata/tvalid/tlast/tready into one port.
// Ports (modport master = stream source, modport slave = stream sink):
//   tdata  [DATA_WIDTH] source -> sink
//   tvalid              source -> sink
//   tlast               source -> sink
//   tready              sink   -> source
interface axis_mm2s_checker_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_mm2s_checker.sv
// rtl/axis_mm2s_checker.sv - MM2S stream sink checking a counter data pattern and tlast placement
// Purpose: accepts the DMA read-back stream, compares each beat against seed + k*W + j,
//   checks tlast lands on beat expected_beats-1, optionally throttles with an LFSR.
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   start                arm pulse, honoured in IDLE or DONE
//   expected_beats, seed sampled on an accepted start
//   stall_en             enables pseudo-random backpressure
//   s_axis               stream sink (slave modport)
//   busy/done/pass       status
//   beat_count, error_count, first_err_beat  results
module axis_mm2s_checker #(
    parameter int DATA_WIDTH = 256,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          expected_beats,
    input  logic [31:0]          seed,
    input  logic                 stall_en,
    axis_mm2s_checker_if.slave   s_axis,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [31:0]          beat_count,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [31:0]          first_err_beat
);
    localparam int W = DATA_WIDTH / 32;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [31:0]          beat_count_q, beat_count_d;
    logic [ERR_WIDTH-1:0] error_count_q, error_count_d;
    logic [31:0]          first_err_q, first_err_d;
    logic [31:0]          base_q, base_d;
    logic [31:0]          exp_beats_q, exp_beats_d;

    logic tready;
    logic accept;
    logic data_mis;
    logic last_exp;
    logic beat_bad;
    logic lfsr_fb;

    // Word j of the current beat must equal base + j; base steps by W per beat,
    // so no multiplier is needed.
    always_comb begin
        data_mis = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (s_axis.tdata[32*j +: 32] != base_q + 32'(j)) begin
                data_mis = 1'b1;
            end
        end
    end

    assign last_exp = (beat_count_q == exp_beats_q - 32'd1);
    assign accept   = s_axis.tvalid && tready;
    // Data and tlast faults on the same beat count as a single failure.
    assign beat_bad = data_mis || (s_axis.tlast != last_exp);
    // Fibonacci taps 16,14,13,11 on a right-shifting register.
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (expected_beats == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Final beat ends the run regardless of tlast; an early tlast ends it too.
                if (accept && (last_exp || s_axis.tlast)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: tready comes only from registered state and stall_en
    always_comb begin
        tready = (state_q == ST_RUN) && (!stall_en || lfsr_q[0]);
        busy   = (state_q == ST_RUN);
        done   = (state_q == ST_DONE);
        pass   = (state_q == ST_DONE) && (error_count_q == '0);
    end

    assign s_axis.tready  = tready;
    assign beat_count     = beat_count_q;
    assign error_count    = error_count_q;
    assign first_err_beat = first_err_q;

    // Datapath next values
    always_comb begin
        lfsr_d        = lfsr_q;
        beat_count_d  = beat_count_q;
        error_count_d = error_count_q;
        first_err_d   = first_err_q;
        base_d        = base_q;
        exp_beats_d   = exp_beats_q;

        if (state_q == ST_RUN) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end

        if ((state_q != ST_RUN) && start) begin
            beat_count_d  = 32'd0;
            error_count_d = '0;
            first_err_d   = 32'hFFFF_FFFF;
            base_d        = seed;
            exp_beats_d   = expected_beats;
        end else if (accept) begin
            beat_count_d = beat_count_q + 32'd1;
            base_d       = base_q + 32'(W);
            if (beat_bad) begin
                if (error_count_q != '1) begin
                    error_count_d = error_count_q + ERR_WIDTH'(1);
                end
                if (first_err_q == 32'hFFFF_FFFF) begin
                    first_err_d = beat_count_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q        <= 16'hACE1;
            beat_count_q  <= 32'd0;
            error_count_q <= '0;
            first_err_q   <= 32'hFFFF_FFFF;
            base_q        <= 32'd0;
            exp_beats_q   <= 32'd0;
        end else begin
            lfsr_q        <= lfsr_d;
            beat_count_q  <= beat_count_d;
            error_count_q <= error_count_d;
            first_err_q   <= first_err_d;
            base_q        <= base_d;
            exp_beats_q   <= exp_beats_d;
        end
    end
endmodule

// File: doc/axis_mm2s_checker.md
# axis_mm2s_checker

Stream sink and data checker that sits directly downstream of the DMA's MM2S AXI-Stream port. It consumes the read-back stream, compares every beat against the deterministic counter pattern written by the S2MM stimulus path, and checks `tlast` placement. It optionally applies pseudo-random backpressure and reports beat count, error count, first failing beat, and a pass/done status to the top level.

## Interface
- `DATA_WIDTH`, default 256: stream data width; must be a multiple of 32. `W = DATA_WIDTH/32` words per beat.
- `ERR_WIDTH`, default 16: width of the error counter.
- `clk`  in  1  single clock; all logic is synchronous to its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle arm pulse; honoured only in IDLE or DONE.
- `expected_beats`  in  32  number of beats expected; sampled on accepted `start`.
- `seed`  in  32  value of word 0 of beat 0; sampled on accepted `start`.
- `stall_en`  in  1  enables LFSR-driven backpressure.
- `s_axis_tdata`  in  DATA_WIDTH  stream data.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tlast`  in  1  stream last.
- `s_axis_tready`  out  1  stream ready.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `error_count == 0`.
- `beat_count`  out  32  beats accepted since the last accepted `start`.
- `error_count`  out  ERR_WIDTH  failing beats; saturates at all-ones.
- `first_err_beat`  out  32  index of the first failing beat; 32'hFFFF_FFFF if there is none.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN: `start` with `expected_beats != 0`. On the same edge:
  - clear `beat_count` and `error_count`;
  - set `first_err_beat` to all-ones;
  - latch `seed` and `expected_beats`;
  - set the expected-word base to `seed`.
- IDLE to DONE: `start` with `expected_beats == 0`. No beats are accepted, and `pass = 1`.
- DONE behaves like IDLE for `start`, so the checker can re-arm. `start` is ignored in RUN.
- Expected data: word j of beat k (bits `32j+31:32j`) is `seed + k*W + j`, modulo 2^32. Keep a 32-bit base register that advances by W per accepted beat. Do not use a multiplier.
- A beat is accepted on an edge where `s_axis_tvalid && s_axis_tready`. A beat fails if either of these holds:
  - any word mismatches;
  - `tlast` disagrees with (index == `expected_beats` - 1).
- A failing beat counts once, even if both data and `tlast` are wrong.
- RUN to DONE, on the accepting edge:
  - when beat `expected_beats` - 1 is accepted (regardless of `tlast`); or
  - when a beat with `tlast = 1` is accepted early. This is an error; stop there.
- `s_axis_tready = (state == RUN) && (!stall_en || lfsr[0])`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Reset value 16'hACE1. It advances every cycle in RUN and holds otherwise.
- Reset values:
  - state IDLE;
  - all outputs 0, except `first_err_beat` = 32'hFFFF_FFFF;
  - LFSR 16'hACE1.
- Reset mid-RUN drops the transfer immediately. `tready` goes 0 asynchronously.

## Timing
- `busy` rises one cycle after the `start` edge. The earliest accepted beat is on the following edge.
- With `stall_en = 0`, `tready` is constant 1 in RUN, giving one beat per cycle.
- `tready` depends only on registered state and `stall_en`. It has no combinational path from `tvalid`, `tdata` or `tlast`.
- `beat_count`, `error_count` and `first_err_beat` update on the accepting edge and are visible the next cycle.
- `done` and `pass` assert the cycle after the final or early-`tlast` beat is accepted. They hold until the next accepted `start` or `reset`.
- Data presented while `tready = 0` is neither checked nor counted.

## Test plan
- Seed 0, 4 beats, no stall, correct stream (beat 1 = words 8..15), `tlast` on beat 3 -> `done` 1 cycle later, `pass` = 1, `beat_count` = 4, `error_count` = 0, `first_err_beat` = FFFF_FFFF.
- Same stream but beat 2 word 0 = 0xDEAD -> `pass` = 0, `error_count` = 1, `first_err_beat` = 2, `beat_count` = 4.
- 4 beats expected, `tlast` on beat 1 -> DONE after 2 beats, `beat_count` = 2, `error_count` = 1, `first_err_beat` = 1. A second case with no `tlast` on beat 3 -> `error_count` = 1, `first_err_beat` = 3.
- `stall_en` = 1, `tvalid` held high, 64 beats -> `tready` low on some cycles, no beat counted while low, `pass` = 1, `beat_count` = 64.
- Seed 0xFFFF_FFFC, 1 beat -> words FFFF_FFFC..FFFF_FFFF, then 0..3 (wrap), `pass` = 1.
- `reset` pulsed after 2 of 8 beats -> all outputs at reset values, `tready` = 0. Re-`start` with 3 beats passes. `start` with `expected_beats` = 0 -> `done` = 1, `pass` = 1, `beat_count` = 0.
